// File: rtl/u_ifu_pq.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue between the synchronous
// instruction SRAM and decode; handles branch redirects, replay flushes and misaligned targets.
module u_ifu_pq #(
    parameter int              XLEN     = 32,
    parameter int              AW       = 16,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       branch,
    input  logic [XLEN-1:0]            br_adr,
    output logic [AW-1:0]              ins_a,
    output logic                       ins_e,
    input  logic [31:0]                ins,
    output logic                       ifu_en,
    output logic [XLEN-1:0]            ifu_pc,
    output logic [31:0]                ifu_ins,
    input  logic                       ifu_rdy,
    output logic                       ifu_err,
    output logic [$clog2(DEPTH+1)-1:0] ifu_cnt
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]     LP_DEPTH = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] LP_STEP  = XLEN'(4);

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_rpc;
    logic [XLEN-1:0] r_ipc;
    logic            r_infl;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [XLEN-1:0] r_q_pc  [DEPTH];
    logic [31:0]     r_q_ins [DEPTH];

    logic            w_pop;
    logic            w_push;
    logic [CW:0]     w_used;
    logic [XLEN-1:0] w_rpc_nxt;

    assign ifu_en  = (r_cnt != '0);
    assign ifu_pc  = r_q_pc[r_rd];
    assign ifu_ins = r_q_ins[r_rd];
    assign ifu_err = r_err;
    assign ifu_cnt = r_cnt;
    assign ins_a   = r_fpc[AW+1:2];

    assign w_pop     = ifu_en & ifu_rdy;
    assign w_push    = r_infl & ~branch & ~flush;
    assign w_rpc_nxt = w_pop ? r_rpc + LP_STEP : r_rpc;

    // Credit counts the in-flight word so a response always has a free slot.
    assign w_used = {1'b0, r_cnt} + (CW+1)'(r_infl) - (CW+1)'(w_pop);
    assign ins_e  = ~rst & ~branch & ~flush & ~r_err & (w_used < LP_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc  <= RESET_PC;
            r_rpc  <= RESET_PC;
            r_ipc  <= '0;
            r_infl <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
            r_rd   <= '0;
            r_wr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]  <= '0;
                r_q_ins[i] <= '0;
            end
        end else if (branch) begin
            r_cnt  <= '0;
            r_rd   <= '0;
            r_wr   <= '0;
            r_infl <= 1'b0;
            r_fpc  <= br_adr;
            r_rpc  <= br_adr;
            r_err  <= |br_adr[1:0];
        end else if (flush) begin
            // A head accepted in the flush cycle counts as consumed.
            r_cnt  <= '0;
            r_rd   <= '0;
            r_wr   <= '0;
            r_infl <= 1'b0;
            r_fpc  <= w_rpc_nxt;
            r_rpc  <= w_rpc_nxt;
        end else begin
            if (w_push) begin
                r_q_pc[r_wr]  <= r_ipc;
                r_q_ins[r_wr] <= ins;
                r_wr          <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_rpc  <= w_rpc_nxt;
            r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_infl <= ins_e;
            if (ins_e) begin
                r_ipc <= r_fpc;
                r_fpc <= r_fpc + LP_STEP;
            end
        end
    end
endmodule
